// File: rtl/linear_pkg.sv
// Shared definitions for the linear (int8 MAC neuron) layer: FSM states,
// datapath widths and address-width helpers used by the MAC and its sequencer.
package linear_pkg;

  localparam int unsigned ACC_WIDTH  = 32;
  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    OUT,
    DONE
  } state_t;

  // Never returns 0, so a size of 1 still yields a legal 1-bit vector.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned waddr_w(input int unsigned in_sz, input int unsigned out_sz);
    return addr_w(in_sz * out_sz);
  endfunction

endpackage

// File: rtl/linear_seq_ctrl_if.sv
// Memory, MAC and result-port bundle between linear_seq_ctrl (master) and the
// surrounding datapath (slave).
interface linear_seq_ctrl_if
  import linear_pkg::*;
#(
  parameter int unsigned INPUT_SIZE  = 4096,
  parameter int unsigned OUTPUT_SIZE = 2,
  parameter int unsigned ACC_WIDTH   = linear_pkg::ACC_WIDTH
);
  localparam int unsigned XW = addr_w(INPUT_SIZE);
  localparam int unsigned WW = waddr_w(INPUT_SIZE, OUTPUT_SIZE);
  localparam int unsigned OW = addr_w(OUTPUT_SIZE);

  logic                        mem_rd_en;
  logic [XW-1:0]               x_addr;
  logic [WW-1:0]               w_addr;
  logic                        mac_valid;
  logic signed [ACC_WIDTH-1:0] mac_y;
  logic                        mac_vout;
  logic                        res_valid;
  logic                        res_ready;
  logic signed [ACC_WIDTH-1:0] res_data;
  logic [OW-1:0]               res_idx;

  modport master (
    output mem_rd_en, x_addr, w_addr, mac_valid, res_valid, res_data, res_idx,
    input  mac_y, mac_vout, res_ready
  );

  modport slave (
    input  mem_rd_en, x_addr, w_addr, mac_valid, res_valid, res_data, res_idx,
    output mac_y, mac_vout, res_ready
  );

endinterface

// File: rtl/linear_seq_ctrl_res_reg.sv
// OUT-stage result holding register with valid/ready handshake.
// Build option LINEAR_SEQ_CTRL_RELU_EN clamps negative MAC results to zero.
module linear_res_reg
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned IDX_W     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_i,
  input  logic                        zero_i,
  input  logic signed [ACC_WIDTH-1:0] y_i,
  input  logic [IDX_W-1:0]            idx_i,
  input  logic                        ready_i,
  output logic                        valid_o,
  output logic signed [ACC_WIDTH-1:0] data_o,
  output logic [IDX_W-1:0]            idx_o,
  output logic                        fire_o
);
  logic                        valid_q;
  logic signed [ACC_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]            idx_q;
  logic signed [ACC_WIDTH-1:0] data_d;

  always_comb begin
    data_d = y_i;
`ifdef LINEAR_SEQ_CTRL_RELU_EN
    if (y_i[ACC_WIDTH-1]) data_d = '0;
`endif
    if (zero_i) data_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else if (load_i || zero_i) begin
      valid_q <= 1'b1;
      data_q  <= data_d;
      idx_q   <= idx_i;
    end else if (fire_o) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idx_o   = idx_q;
  assign fire_o  = valid_q && ready_i;

endmodule

// File: rtl/linear_seq_ctrl.sv
// Sequencer running OUTPUT_SIZE neurons back-to-back on one shared MAC.
// Optional build macro LINEAR_SEQ_CTRL_RELU_EN (applied in linear_res_reg).
module linear_seq_ctrl
  import linear_pkg::*;
#(
  parameter int unsigned INPUT_SIZE    = 4096,
  parameter int unsigned OUTPUT_SIZE   = 2,
  parameter int unsigned ACC_WIDTH     = linear_pkg::ACC_WIDTH,
  parameter int unsigned DRAIN_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  linear_seq_ctrl_if.master bus
);
  localparam int unsigned XW = addr_w(INPUT_SIZE);
  localparam int unsigned WW = waddr_w(INPUT_SIZE, OUTPUT_SIZE);
  localparam int unsigned OW = addr_w(OUTPUT_SIZE);
  localparam int unsigned DW = addr_w(DRAIN_TIMEOUT);

  state_t        state_q;
  logic [XW-1:0] i_q;
  logic [OW-1:0] o_q;
  logic [WW-1:0] base_q;
  logic [DW-1:0] dcnt_q;
  logic          busy_q, done_q, err_q, rd_q, mv_q;
  logic          cap, tmo, fire;

  // The first DRAIN cycle (dcnt_q == 0) is too early for a genuine result.
  assign cap = (state_q == DRAIN) && (dcnt_q != '0) && bus.mac_vout;
  assign tmo = (state_q == DRAIN) && !bus.mac_vout && (dcnt_q == DW'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      o_q     <= '0;
      base_q  <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      mv_q    <= 1'b0;
    end else begin
      mv_q   <= rd_q;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          state_q <= STREAM;
          err_q   <= 1'b0;
          i_q     <= '0;
          o_q     <= '0;
          base_q  <= '0;
          busy_q  <= 1'b1;
          rd_q    <= 1'b1;
        end
        STREAM: begin
          if (bus.mac_vout) err_q <= 1'b1;
          if (i_q == XW'(INPUT_SIZE - 1)) begin
            state_q <= DRAIN;
            rd_q    <= 1'b0;
            dcnt_q  <= '0;
          end else begin
            i_q <= i_q + XW'(1);
          end
        end
        DRAIN: begin
          if ((dcnt_q == '0) && bus.mac_vout) err_q <= 1'b1;
          if (cap) begin
            state_q <= OUT;
          end else if (tmo) begin
            err_q   <= 1'b1;
            state_q <= OUT;
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        OUT: if (fire) begin
          if (o_q == OW'(OUTPUT_SIZE - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= STREAM;
            o_q     <= o_q + OW'(1);
            base_q  <= base_q + WW'(INPUT_SIZE);
            i_q     <= '0;
            rd_q    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  linear_res_reg #(
    .ACC_WIDTH (ACC_WIDTH),
    .IDX_W     (OW)
  ) u_res_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (cap),
    .zero_i  (tmo),
    .y_i     (bus.mac_y),
    .idx_i   (o_q),
    .ready_i (bus.res_ready),
    .valid_o (bus.res_valid),
    .data_o  (bus.res_data),
    .idx_o   (bus.res_idx),
    .fire_o  (fire)
  );

  assign bus.mem_rd_en = rd_q;
  assign bus.x_addr    = i_q;
  assign bus.w_addr    = base_q + WW'(i_q);
  assign bus.mac_valid = mv_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: doc/linear_seq_ctrl.md
Name: linear_seq_ctrl

Overview:
- Sequencer for the streaming int8 MAC neuron (`linear`) in the stress-detector inference path.
- Runs OUTPUT_SIZE neurons back-to-back on one shared MAC. For each neuron it reads INPUT_SIZE activation/weight pairs from the activation buffer and weight ROM, and drives the MAC valid strobe.
- Captures each 32-bit dot product and presents it on a valid/ready result port to the next layer.

Parameters:
- INPUT_SIZE, 4096, dot-product length per neuron; must match the MAC's INPUT_SIZE.
- OUTPUT_SIZE, 2, number of neurons per layer run.
- ACC_WIDTH, 32, MAC result width.
- DRAIN_TIMEOUT, 8, max cycles in DRAIN before error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin a layer run
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle pulse after the last result handshake
- err  out  1  sticky protocol error, cleared only by reset or an accepted start
- mem_rd_en  out  1  read strobe to both memories; synchronous read, latency 1
- x_addr  out  $clog2(INPUT_SIZE)  activation buffer address
- w_addr  out  $clog2(INPUT_SIZE*OUTPUT_SIZE)  weight ROM address
- mac_valid  out  1  drives MAC valid_in
- mac_y  in  ACC_WIDTH signed  MAC y_out
- mac_vout  in  1  MAC valid_out
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  ACC_WIDTH signed  neuron result
- res_idx  out  $clog2(OUTPUT_SIZE)  neuron index of res_data

Behaviour:
- Reset: rst_n low asynchronously clears all outputs, counters and err to 0, and sets state to IDLE.
- The MAC reset must be driven from the same net (inverted), so a mid-run reset also clears the MAC's partial accumulator.
- States are IDLE, STREAM, DRAIN, OUT, DONE.
- IDLE:
  - start=1 goes to STREAM, clears err, and sets neuron counter o=0 and input counter i=0.
  - start while not IDLE is ignored.
- STREAM:
  - mem_rd_en=1, x_addr=i, w_addr=o*INPUT_SIZE+i. The multiply is replaced by a running base register incremented by INPUT_SIZE per neuron.
  - i increments every cycle. When i==INPUT_SIZE-1, go to DRAIN.
- mac_valid is mem_rd_en registered by one cycle (matches memory latency).
- DRAIN:
  - Wait for mac_vout. When it is seen, register res_data<=mac_y and res_idx<=o, then go to OUT.
  - Expected arrival is the 2nd DRAIN cycle.
  - If mac_vout is not seen within DRAIN_TIMEOUT cycles, set err, register res_data=0, and go to OUT.
- mac_vout asserted while in STREAM, or in the first DRAIN cycle, sets err; that mac_vout is not captured.
- OUT:
  - res_valid=1, with res_data and res_idx held stable until res_valid && res_ready.
  - On handshake: if o==OUTPUT_SIZE-1, go to DONE; otherwise o++, i=0, go to STREAM.
  - res_ready=1 while not OUT is ignored.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in IDLE only.
- Timing with res_ready tied high:
  - Start accepted in cycle 0; reads in cycles 1..N.
  - mac_vout in cycle N+2; res_valid in cycle N+3.
  - Per-neuron period is N+3 cycles.
- Arithmetic: res_data is a pass-through of the MAC's ACC_WIDTH signed value; no truncation.

Optional Feature:
- LINEAR_SEQ_CTRL_RELU_EN
- Defined: the value registered into res_data is max(mac_y,0), i.e. negative results become 0.
- Undefined: res_data = mac_y unchanged.
- err and timeout behaviour are identical in both builds.

Decomposition:
- Shared package linear_pkg holds:
  - the state enum (IDLE/STREAM/DRAIN/OUT/DONE);
  - ACC_WIDTH and DATA_WIDTH constants;
  - address-width helper functions used by both the MAC and this controller.
- Optional sub-module linear_res_reg: the OUT-stage result holding register with valid/ready and optional ReLU.
- The FSM and counters stay in the top module.

Test Plan (INPUT_SIZE=4, OUTPUT_SIZE=3, the real MAC instantiated, memories behavioural):
- Reset, then start with x=1,2,3,4 and weight rows {1,1,1,1}, {-1,0,0,0}, {2,2,2,2}, res_ready=1 -> results 10, -1, 20 with idx 0, 1, 2. Under RELU_EN the second result is 0. Results arrive 7 cycles apart; done pulses once; busy falls with done.
- Address check -> w_addr sequence 0..11 contiguous; x_addr wraps 0..3 per neuron; mac_valid asserted exactly 12 cycles total.
- res_ready held low for 5 cycles on neuron 1 -> res_data/res_idx stable, no new reads, no MAC strobes; run resumes one cycle after ready rises.
- start pulsed mid-STREAM -> ignored; counters and addresses undisturbed; results unchanged.
- Tie mac_vout low (MAC stubbed) -> err rises after 8 DRAIN cycles; res_valid presented with 0; run still completes with done.
- Assert rst_n low during STREAM of neuron 1, then restart -> all outputs 0 immediately; the next run yields the correct 10, -1, 20 (no stale accumulator); err=0.
